// File: rtl/morra_giocatore.sv
// Automatic two-player match driver for the MorraCinese game FSM.
// Plays LFSR-generated moves, tallies manche results and reports the match outcome.
module morra_giocatore #(
    parameter logic [7:0]  SEED1      = 8'hA5,
    parameter logic [7:0]  SEED2      = 8'h3E,
    parameter int unsigned MAX_MANCHE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       START,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       INIZIA,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] RISULTATO,
    output logic [3:0] VITTORIE1,
    output logic [3:0] VITTORIE2,
    output logic [3:0] PAREGGI,
    output logic       TIMEOUT
);

    localparam int unsigned CNT_W = 8;
    localparam logic [7:0] SEED1_EFF = (SEED1 == 8'h00) ? 8'h01 : SEED1;
    localparam logic [7:0] SEED2_EFF = (SEED2 == 8'h00) ? 8'h01 : SEED2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MANCHE);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PLAY,
        CHECK,
        FINE
    } state_t;

    state_t           state;
    logic [7:0]       lfsr1;
    logic [7:0]       lfsr2;
    logic [CNT_W-1:0] manche_cnt;

    // Move 00 means "no move", so an LFSR value of 00 is played as sasso.
    function automatic logic [1:0] map_move(input logic [1:0] v);
        return (v == 2'b00) ? 2'b01 : v;
    endfunction

    // x^8+x^6+x^5+x^4+1, Fibonacci, shifting left.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Match sequencer; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr1      <= SEED1_EFF;
            lfsr2      <= SEED2_EFF;
            manche_cnt <= '0;
            PRIMO      <= 2'b00;
            SECONDO    <= 2'b00;
            INIZIA     <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            RISULTATO  <= 2'b00;
            VITTORIE1  <= 4'd0;
            VITTORIE2  <= 4'd0;
            PAREGGI    <= 4'd0;
            TIMEOUT    <= 1'b0;
        end else begin
            PRIMO   <= 2'b00;
            SECONDO <= 2'b00;
            INIZIA  <= 1'b0;
            DONE    <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state      <= INIT;
                        INIZIA     <= 1'b1;
                        BUSY       <= 1'b1;
                        manche_cnt <= '0;
                        VITTORIE1  <= 4'd0;
                        VITTORIE2  <= 4'd0;
                        PAREGGI    <= 4'd0;
                        RISULTATO  <= 2'b00;
                        TIMEOUT    <= 1'b0;
                    end
                end
                INIT: begin
                    state   <= PLAY;
                    PRIMO   <= map_move(lfsr1[1:0]);
                    SECONDO <= map_move(lfsr2[1:0]);
                end
                PLAY: begin
                    state      <= CHECK;
                    lfsr1      <= lfsr_next(lfsr1);
                    lfsr2      <= lfsr_next(lfsr2);
                    manche_cnt <= manche_cnt + CNT_W'(1);
                end
                CHECK: begin
                    case (MANCHE)
                        2'b01:   VITTORIE1 <= sat_inc(VITTORIE1);
                        2'b10:   VITTORIE2 <= sat_inc(VITTORIE2);
                        2'b11:   PAREGGI   <= sat_inc(PAREGGI);
                        default: ;
                    endcase
                    // A real match result takes priority over the manche limit.
                    if (PARTITA != 2'b00) begin
                        state     <= FINE;
                        RISULTATO <= PARTITA;
                        DONE      <= 1'b1;
                        BUSY      <= 1'b0;
                    end else if (manche_cnt == MAX_CNT) begin
                        state     <= FINE;
                        RISULTATO <= 2'b00;
                        TIMEOUT   <= 1'b1;
                        DONE      <= 1'b1;
                        BUSY      <= 1'b0;
                    end else begin
                        state   <= PLAY;
                        PRIMO   <= map_move(lfsr1[1:0]);
                        SECONDO <= map_move(lfsr2[1:0]);
                    end
                end
                FINE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morra_giocatore.sv
// Randomised scoreboard bench for morra_giocatore with a scripted game model.
// Expected match outcomes are queued at START and compared when DONE appears.
module tb_morra_giocatore;

    localparam int unsigned MAXM = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       START = 1'b0;
    logic [1:0] MANCHE = 2'b00;
    logic [1:0] PARTITA = 2'b00;
    logic [1:0] PRIMO, SECONDO, RISULTATO;
    logic       INIZIA, BUSY, DONE, TIMEOUT;
    logic [3:0] VITTORIE1, VITTORIE2, PAREGGI;

    morra_giocatore #(
        .SEED1     (8'hA5),
        .SEED2     (8'h3E),
        .MAX_MANCHE(MAXM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .START    (START),
        .MANCHE   (MANCHE),
        .PARTITA  (PARTITA),
        .PRIMO    (PRIMO),
        .SECONDO  (SECONDO),
        .INIZIA   (INIZIA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RISULTATO(RISULTATO),
        .VITTORIE1(VITTORIE1),
        .VITTORIE2(VITTORIE2),
        .PAREGGI  (PAREGGI),
        .TIMEOUT  (TIMEOUT)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] m;       // 2-bit MANCHE answer per manche
        int          k_end;   // manche carrying non-zero PARTITA, 0 = never
        logic [1:0]  p;
    } script_t;

    typedef struct {
        int         done_cyc;
        logic [3:0] v1, v2, pg;
        logic [1:0] ris;
        logic       to;
    } exp_t;

    exp_t    expq[$];
    int      inizq[$];
    script_t scripts[$];

    int checks = 0;
    int errors = 0;
    int ndone  = 0;
    bit armed  = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [1:0] play_of(input logic [1:0] v);
        return (v == 2'b00) ? 2'b01 : v;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Outcome of a scripted match whose START is sampled at the end of cycle c.
    function automatic exp_t model(input script_t s, input int c);
        exp_t e;
        int   n, c1, c2, cp;
        bit   ended;
        ended = (s.k_end >= 1) && (s.k_end <= int'(MAXM));
        n = ended ? s.k_end : int'(MAXM);
        c1 = 0; c2 = 0; cp = 0;
        for (int i = 0; i < n; i++) begin
            case (s.m[2*i +: 2])
                2'b01:   c1++;
                2'b10:   c2++;
                2'b11:   cp++;
                default: ;
            endcase
        end
        e.v1       = 4'(sat15(c1));
        e.v2       = 4'(sat15(c2));
        e.pg       = 4'(sat15(cp));
        e.to       = !ended;
        e.ris      = ended ? s.p : 2'b00;
        e.done_cyc = c + 2 * n + 2;
        return e;
    endfunction

    function automatic script_t mk_const(input logic [1:0] v, input int kend, input logic [1:0] p);
        script_t s;
        s.m = {32{v}};
        s.k_end = kend;
        s.p = p;
        return s;
    endfunction

    function automatic script_t mk_rand();
        script_t s;
        s.m = {$urandom, $urandom};
        s.k_end = $urandom_range(0, 24);
        s.p = 2'($urandom_range(1, 3));
        return s;
    endfunction

    // Game model: answers a move one cycle later, junk on all other cycles.
    logic [1:0] s_primo = 2'b00;
    logic       s_iniz  = 1'b0;
    script_t    cur;
    int         idx = 0;

    initial forever begin
        @(negedge clk);
        s_primo = PRIMO;
        s_iniz  = INIZIA;
    end

    initial begin
        cur = mk_const(2'b00, 0, 2'b00);
        forever begin
            @(posedge clk);
            #1;
            if (s_iniz) begin
                if (scripts.size() != 0) cur = scripts.pop_front();
                idx = 0;
            end
            if (s_primo != 2'b00) begin
                MANCHE  = (idx < 32) ? cur.m[2*idx +: 2] : 2'b00;
                PARTITA = (idx + 1 == cur.k_end) ? cur.p : 2'b00;
                idx++;
            end else begin
                MANCHE  = 2'($urandom);
                PARTITA = 2'($urandom);
            end
        end
    end

    // Monitor: INIZIA timing, moves, BUSY, and match outcome on DONE.
    logic [7:0] m1 = 8'hA5;
    logic [7:0] m2 = 8'h3E;
    bit         busy_exp = 1'b0;

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (armed) begin
            if (INIZIA) begin
                busy_exp = 1'b1;
                if (inizq.size() == 0) chk("inizia_unexpected", cyc, -1);
                else chk("inizia_cycle", cyc, inizq.pop_front());
            end
            if (DONE) begin
                busy_exp = 1'b0;
                ndone++;
                if (expq.size() == 0) begin
                    chk("done_unexpected", cyc, -1);
                end else begin
                    e = expq.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("vittorie1", int'(VITTORIE1), int'(e.v1));
                    chk("vittorie2", int'(VITTORIE2), int'(e.v2));
                    chk("pareggi", int'(PAREGGI), int'(e.pg));
                    chk("risultato", int'(RISULTATO), int'(e.ris));
                    chk("timeout", int'(TIMEOUT), int'(e.to));
                end
            end
            if (PRIMO != 2'b00 || SECONDO != 2'b00) begin
                chk("primo", int'(PRIMO), int'(play_of(m1[1:0])));
                chk("secondo", int'(SECONDO), int'(play_of(m2[1:0])));
                m1 = lfsr_step(m1);
                m2 = lfsr_step(m2);
            end
            chk("busy", int'(BUSY), int'(busy_exp));
            if (!rst_n) begin
                m1 = 8'hA5;
                m2 = 8'h3E;
                busy_exp = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_outs"},
            int'({PRIMO, SECONDO, INIZIA, BUSY, DONE, TIMEOUT, RISULTATO,
                  VITTORIE1, VITTORIE2, PAREGGI}), 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(BUSY == 1'b0 && DONE == 1'b0 && INIZIA == 1'b0) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) chk("idle_timeout", t, 0);
    endtask

    // Waits for DONE while poking START only during busy cycles, where it must be ignored.
    task automatic wait_done(input int target);
        int t = 0;
        while (ndone < target && t < 200) begin
            START = BUSY && ($urandom_range(0, 2) == 0);
            tick();
            t++;
        end
        START = 1'b0;
        if (ndone < target) chk("done_timeout", ndone, target);
    endtask

    task automatic run_match(input script_t s);
        int target;
        wait_idle();
        START = 1'b1;
        scripts.push_back(s);
        inizq.push_back(cyc + 1);
        expq.push_back(model(s, cyc));
        target = ndone + 1;
        tick();
        wait_done(target);
    endtask

    initial begin
        int      c, target, t, nd0;
        script_t s;
        exp_t    e;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("por");
        armed = 1'b1;
        tick();

        run_match(mk_const(2'b01, 3, 2'b01));
        run_match(mk_const(2'b11, 0, 2'b00));
        run_match(mk_const(2'b11, int'(MAXM), 2'b10));
        run_match(mk_const(2'b10, 0, 2'b00));
        run_match(mk_const(2'b00, 1, 2'b11));
        run_match(mk_const(2'b11, 4, 2'b10));
        for (int i = 0; i < 8; i++) run_match(mk_rand());

        // START held high across three back-to-back matches.
        wait_idle();
        START = 1'b1;
        c = cyc;
        for (int j = 0; j < 3; j++) begin
            s = mk_rand();
            scripts.push_back(s);
            inizq.push_back(c + 1);
            e = model(s, c);
            expq.push_back(e);
            c = e.done_cyc + 1;
        end
        target = ndone + 3;
        t = 0;
        while (ndone < target && t < 600) begin
            if (ndone >= target - 1 && BUSY) START = 1'b0;
            tick();
            t++;
        end
        START = 1'b0;
        if (ndone < target) chk("held_done_timeout", ndone, target);

        // Reset asserted in cycle 5 of a match abandons it without DONE.
        wait_idle();
        nd0 = ndone;
        START = 1'b1;
        scripts.push_back(mk_const(2'b11, 0, 2'b00));
        inizq.push_back(cyc + 1);
        c = cyc;
        tick();
        START = 1'b0;
        while (cyc < c + 5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("midreset");
        repeat (10) tick();
        chk("no_done_after_reset", ndone, nd0);

        run_match(mk_const(2'b01, 2, 2'b01));
        run_match(mk_rand());
        repeat (3) tick();
        chk("queues_drained", expq.size() + inizq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morra_giocatore.md
# morra_giocatore

Automatic two-player match driver for the MorraCinese game FSM. It drives the game's move and start inputs, reads back the manche and match results, and keeps per-player score counters. It stops when the game declares a match result or when a safety manche limit is reached, then reports the outcome with a one-cycle done pulse. It sits in front of the game FSM as the stimulus side of the same PRIMO/SECONDO/INIZIA ↔ MANCHE/PARTITA interface, for self-test and demo play.

## Interface
- SEED1, 8'hA5, initial LFSR state for player 1; a value of 0 is replaced by 8'h01
- SEED2, 8'h3E, initial LFSR state for player 2; a value of 0 is replaced by 8'h01
- MAX_MANCHE, 16, number of PLAY cycles after which the match is aborted with TIMEOUT (range 1..255)
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset: synchronous, active-low
- START  in  1  request a new match; sampled only in IDLE
- MANCHE  in  2  game manche result: 00 invalid/none, 01 player 1 wins, 10 player 2 wins, 11 draw
- PARTITA  in  2  game match result: 00 ongoing, 01 player 1 wins, 10 player 2 wins, 11 draw
- PRIMO  out  2  player 1 move: 00 none, 01 sasso, 10 carta, 11 forbice
- SECONDO  out  2  player 2 move, same encoding as PRIMO
- INIZIA  out  1  game (re)start request, one cycle
- BUSY  out  1  a match is in progress
- DONE  out  1  one-cycle pulse at the end of a match
- RISULTATO  out  2  latched PARTITA of the last match; 00 after a timeout
- VITTORIE1, VITTORIE2, PAREGGI  out  4 each  manche win/draw counters, saturating at 15
- TIMEOUT  out  1  last match hit MAX_MANCHE; held until the next accepted START

## Operation
- States: IDLE, INIT, PLAY, CHECK, FINE.
- **IDLE**
  - PRIMO = SECONDO = 00, INIZIA = 0, BUSY = 0.
  - START = 1 → INIT.
  - On accepting START, clear VITTORIE1/2, PAREGGI, RISULTATO, TIMEOUT and the manche counter. LFSRs are not reseeded.
- **INIT** (one cycle)
  - INIZIA = 1, PRIMO = SECONDO = 00, BUSY = 1.
  - Next state: PLAY. The game response to this cycle is ignored.
- **PLAY** (one cycle)
  - PRIMO = map(lfsr1[1:0]), SECONDO = map(lfsr2[1:0]).
  - map: 00 → 01; any other value passes through unchanged.
  - Both LFSRs advance at the end of the cycle. Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form, shift left, new bit 0 = b7^b5^b4^b3.
  - Manche counter increments. Next state: CHECK.
- **CHECK** (one cycle)
  - PRIMO = SECONDO = 00.
  - MANCHE/PARTITA present the game's response to the preceding PLAY move.
  - MANCHE 01 → VITTORIE1+1; 10 → VITTORIE2+1; 11 → PAREGGI+1; 00 → no count. All counters saturate at 15.
  - PARTITA ≠ 00 → latch RISULTATO = PARTITA, go to FINE.
  - Otherwise, if manche counter == MAX_MANCHE → TIMEOUT = 1, RISULTATO = 00, go to FINE.
  - Otherwise → PLAY.
- **FINE** (one cycle)
  - DONE = 1, BUSY = 0, moves = 00. Next state: IDLE.
- START while BUSY is ignored. START held high continuously starts a new match on every pass through IDLE.

## Timing
- Reset values:
  - PRIMO = SECONDO = 00; INIZIA, BUSY, DONE, TIMEOUT = 0; RISULTATO = 00.
  - VITTORIE1 = VITTORIE2 = PAREGGI = 0; state = IDLE; lfsr1 = SEED1, lfsr2 = SEED2.
- All outputs are registered.
- Game contract: moves presented in cycle n produce MANCHE/PARTITA that are valid in cycle n+1.
- Latency with START sampled at edge 0:
  - INIZIA high in cycle 1.
  - First move in cycle 2, checked in cycle 3.
  - Manche k is played in cycle 2k and checked in cycle 2k+1.
  - DONE is high in cycle 2k+2 after the final manche k.
- rst_n low mid-match: at the next edge all outputs return to their reset values and the match is abandoned. There is no DONE. The next match re-issues INIZIA, so the game is re-synchronised.
- Same-cycle PARTITA ≠ 00 and manche counter == MAX_MANCHE: the PARTITA result wins and TIMEOUT stays 0.
- The MANCHE of the final checked manche is always counted, including on the cycle that ends the match.

## Test plan
- Reset, then first match with default seeds, START pulse at edge 0:
  - INIZIA = 1 only in cycle 1.
  - Cycle 2: PRIMO = 01, SECONDO = 10.
  - Cycle 3: PRIMO = SECONDO = 00.
- Bench game model returns MANCHE = 01 three times, with PARTITA = 01 on the third check:
  - VITTORIE1 = 3, VITTORIE2 = PAREGGI = 0, RISULTATO = 01.
  - DONE high for exactly cycle 8; BUSY low from cycle 8.
- MAX_MANCHE = 4, model always returns MANCHE = 11 and PARTITA = 00:
  - PAREGGI = 4, TIMEOUT = 1, RISULTATO = 00, DONE in cycle 10.
  - Same run with PARTITA = 10 on the 4th check: RISULTATO = 10, TIMEOUT = 0.
- Saturation: MAX_MANCHE = 20, model always returns MANCHE = 10 → VITTORIE2 = 15 at DONE.
- rst_n low in cycle 5 of a match → all outputs at reset values in cycle 6, no DONE pulse. A later START gives INIZIA one cycle after START is sampled.
- START pulsed during PLAY/CHECK has no effect. START held high → a new INIT follows each FINE → IDLE, and counters clear on each accepted START.
